// File: rtl/mul_iter_radix4_if.sv
// EX-stage handshake bundle for the iterative multiplier: opcode, operands, HI/LO, start/annul in;
// 64-bit {hi,lo} result plus ready/busy out. Default opcode encodings apply if alu_defines.vh is absent.
`ifndef MULT_CONTROL
`define MULT_CONTROL 6'h18
`endif
`ifndef MULTU_CONTROL
`define MULTU_CONTROL 6'h19
`endif
`ifndef MADD_CONTROL
`define MADD_CONTROL 6'h1c
`endif
`ifndef MADDU_CONTROL
`define MADDU_CONTROL 6'h1d
`endif
`ifndef MSUB_CONTROL
`define MSUB_CONTROL 6'h1e
`endif
`ifndef MSUBU_CONTROL
`define MSUBU_CONTROL 6'h1f
`endif

interface mul_iter_radix4_if;
  logic [5:0]  op;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  modport master (
    output op, opdata1_i, opdata2_i, hi_i, lo_i, start_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  op, opdata1_i, opdata2_i, hi_i, lo_i, start_i, annul_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/mul_iter_radix4.sv
// Iterative radix-4 Booth multiplier for MULT/MULTU: 17 Booth steps, registered {hi,lo} result.
// Define MUL_MADD_EN to add the ACC state and MADD/MADDU/MSUB/MSUBU.
module mul_iter_radix4 (
  input  logic               clk,
  input  logic               rst,
  mul_iter_radix4_if.slave   bus
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
`ifdef MUL_MADD_EN
    StAcc  = 2'd2,
`endif
    StDone = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [33:0] mcand_q, mcand_d;
  // {35-bit accumulator, 34-bit multiplier}; the multiplier shifts out as the product shifts in.
  logic [68:0] pp_q, pp_d;
  logic        qm1_q, qm1_d;
  logic [63:0] result_q, result_d;
`ifdef MUL_MADD_EN
  logic        acc_q, acc_d;
  logic        sub_q, sub_d;
  logic        op_acc, op_sub;
`else
  logic        unused_hilo;
  assign unused_hilo = ^{bus.hi_i, bus.lo_i};
`endif

  logic        op_ok, op_signed;
  logic [33:0] mcand_ext, mplier_ext;
  logic [34:0] m_ext, term, sum_hi;
  logic [68:0] pp_step;

  always_comb begin
    op_ok     = 1'b0;
    op_signed = 1'b0;
`ifdef MUL_MADD_EN
    op_acc    = 1'b0;
    op_sub    = 1'b0;
`endif
    case (bus.op)
      `MULT_CONTROL:  begin op_ok = 1'b1; op_signed = 1'b1; end
      `MULTU_CONTROL: op_ok = 1'b1;
`ifdef MUL_MADD_EN
      `MADD_CONTROL:  begin op_ok = 1'b1; op_signed = 1'b1; op_acc = 1'b1; end
      `MADDU_CONTROL: begin op_ok = 1'b1; op_acc = 1'b1; end
      `MSUB_CONTROL:  begin op_ok = 1'b1; op_signed = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
      `MSUBU_CONTROL: begin op_ok = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign mcand_ext  = op_signed ? {{2{bus.opdata1_i[31]}}, bus.opdata1_i}
                                : {2'b00, bus.opdata1_i};
  assign mplier_ext = op_signed ? {{2{bus.opdata2_i[31]}}, bus.opdata2_i}
                                : {2'b00, bus.opdata2_i};

  // One Booth step: recode {q[1], q[0], q[-1]}, add into the accumulator, shift right by 2.
  always_comb begin
    m_ext = {mcand_q[33], mcand_q};
    case ({pp_q[1:0], qm1_q})
      3'b001, 3'b010: term = m_ext;
      3'b011:         term = m_ext << 1;
      3'b100:         term = -(m_ext << 1);
      3'b101, 3'b110: term = -m_ext;
      default:        term = '0;
    endcase
    sum_hi  = pp_q[68:34] + term;
    pp_step = $signed({sum_hi, pp_q[33:0]}) >>> 2;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    pp_d     = pp_q;
    qm1_d    = qm1_q;
    result_d = result_q;
`ifdef MUL_MADD_EN
    acc_d    = acc_q;
    sub_d    = sub_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.start_i && !bus.annul_i && op_ok) begin
          state_d = StCalc;
          cnt_d   = '0;
          mcand_d = mcand_ext;
          pp_d    = {35'd0, mplier_ext};
          qm1_d   = 1'b0;
`ifdef MUL_MADD_EN
          acc_d   = op_acc;
          sub_d   = op_sub;
`endif
        end
      end
      StCalc: begin
        if (bus.annul_i) begin
          state_d = StIdle;
        end else begin
          pp_d  = pp_step;
          qm1_d = pp_q[1];
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd16) begin
`ifdef MUL_MADD_EN
            if (acc_q) state_d = StAcc;
            else
`endif
            begin
              state_d  = StDone;
              result_d = pp_step[63:0];
            end
          end
        end
      end
`ifdef MUL_MADD_EN
      StAcc: begin
        // HI/LO are taken here rather than at accept so EX can forward late writes.
        if (bus.annul_i) begin
          state_d = StIdle;
        end else begin
          state_d  = StDone;
          result_d = sub_q ? {bus.hi_i, bus.lo_i} - pp_q[63:0]
                           : {bus.hi_i, bus.lo_i} + pp_q[63:0];
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      pp_q     <= '0;
      qm1_q    <= 1'b0;
      result_q <= '0;
`ifdef MUL_MADD_EN
      acc_q    <= 1'b0;
      sub_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      pp_q     <= pp_d;
      qm1_q    <= qm1_d;
      result_q <= result_d;
`ifdef MUL_MADD_EN
      acc_q    <= acc_d;
      sub_q    <= sub_d;
`endif
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = (state_q == StDone);
  assign bus.busy_o   = (state_q != StIdle);

endmodule

// File: tb/tb_mul_iter_radix4.sv
// Bench for mul_iter_radix4: table of known products, random ops against an arithmetic model,
// and hand sequences for annul, reset, busy/unsupported starts.
`timescale 1ns/1ps
`ifndef MULT_CONTROL
`define MULT_CONTROL 6'h18
`endif
`ifndef MULTU_CONTROL
`define MULTU_CONTROL 6'h19
`endif
`ifndef MADD_CONTROL
`define MADD_CONTROL 6'h1c
`endif
`ifndef MADDU_CONTROL
`define MADDU_CONTROL 6'h1d
`endif
`ifndef MSUB_CONTROL
`define MSUB_CONTROL 6'h1e
`endif
`ifndef MSUBU_CONTROL
`define MSUBU_CONTROL 6'h1f
`endif

module tb_mul_iter_radix4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [63:0] last_exp = 64'h0;

  mul_iter_radix4_if bus ();
  mul_iter_radix4 dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a, b, h, l;
    logic [63:0] exp;
    int          lat;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [5:0] opc, input logic [31:0] a, b, h, l);
    logic [63:0] sp, up, hl;
    sp = 64'(longint'($signed(a)) * longint'($signed(b)));
    up = {32'd0, a} * {32'd0, b};
    hl = {h, l};
    case (opc)
      `MULT_CONTROL:  return sp;
      `MULTU_CONTROL: return up;
      `MADD_CONTROL:  return hl + sp;
      `MADDU_CONTROL: return hl + up;
      `MSUB_CONTROL:  return hl - sp;
      `MSUBU_CONTROL: return hl - up;
      default:        return 64'h0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hffff_ffff;
      3:       return 32'h7fff_ffff;
      default: return $urandom();
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of the cycle after the expected pulse.
  task automatic run_op(input string name, input logic [5:0] opc, input logic [31:0] a, b, h, l,
                        input logic [63:0] exp, input int lat, input bit hold);
    int seen;
    bit busy_ok;
    bus.op = opc; bus.opdata1_i = a; bus.opdata2_i = b; bus.hi_i = h; bus.lo_i = l;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = hold;
    bus.op = `MULTU_CONTROL;
    bus.opdata1_i = ~a;
    bus.opdata2_i = b ^ 32'h5a5a_0f0f;
    seen = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= lat + 4 && seen == 0; k++) begin
      @(negedge clk);
      if (!bus.busy_o) busy_ok = 1'b0;
      if (bus.ready_o) seen = k;
    end
    bus.start_i = 1'b0;
    check({name, " latency"}, 64'(seen), 64'(lat));
    check({name, " result"}, bus.result_o, exp);
    check({name, " busy"}, 64'(busy_ok), 64'd1);
    @(negedge clk);
    check({name, " idle after pulse"}, {62'd0, bus.ready_o, bus.busy_o}, 64'd0);
    last_exp = exp;
  endtask

  // Drives a start that must be ignored; checks nothing leaves IDLE.
  task automatic ignored_start(input string name, input logic [5:0] opc, input bit annul);
    bit moved;
    moved = 1'b0;
    bus.op = opc; bus.opdata1_i = 32'd9; bus.opdata2_i = 32'd9;
    bus.start_i = 1'b1; bus.annul_i = annul;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.busy_o || bus.ready_o) moved = 1'b1;
    end
    bus.start_i = 1'b0; bus.annul_i = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy_o || bus.ready_o) moved = 1'b1;
    end
    check({name, " no activity"}, 64'(moved), 64'd0);
    check({name, " result held"}, bus.result_o, last_exp);
  endtask

  initial begin
    bus.op = '0; bus.opdata1_i = '0; bus.opdata2_i = '0; bus.hi_i = '0; bus.lo_i = '0;
    bus.start_i = 1'b0; bus.annul_i = 1'b0;
    repeat (2) @(negedge clk);
    check("reset result", bus.result_o, 64'h0);
    check("reset ready/busy", {62'd0, bus.ready_o, bus.busy_o}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    tbl.push_back('{`MULTU_CONTROL, 32'd7, 32'd6, 32'd0, 32'd0, 64'h0000_0000_0000_002a, 18});
    tbl.push_back('{`MULT_CONTROL, 32'hffff_ffff, 32'd1, 32'd0, 32'd0, 64'hffff_ffff_ffff_ffff, 18});
    tbl.push_back('{`MULTU_CONTROL, 32'hffff_ffff, 32'd1, 32'd0, 32'd0, 64'h0000_0000_ffff_ffff, 18});
    tbl.push_back('{`MULTU_CONTROL, 32'hffff_ffff, 32'hffff_ffff, 32'd0, 32'd0,
                    64'hffff_fffe_0000_0001, 18});
    tbl.push_back('{`MULT_CONTROL, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0,
                    64'h4000_0000_0000_0000, 18});
    tbl.push_back('{`MULT_CONTROL, 32'h7fff_ffff, 32'h8000_0000, 32'd0, 32'd0,
                    64'hc000_0000_8000_0000, 18});
    tbl.push_back('{`MULT_CONTROL, 32'd0, 32'h1234_5678, 32'd0, 32'd0, 64'h0, 18});
`ifdef MUL_MADD_EN
    tbl.push_back('{`MADDU_CONTROL, 32'd1, 32'd1, 32'd0, 32'hffff_ffff, 64'h0000_0001_0000_0000, 19});
    tbl.push_back('{`MSUB_CONTROL, 32'd2, 32'd3, 32'd0, 32'd0, 64'hffff_ffff_ffff_fffa, 19});
`endif
    // Consecutive entries start in the IDLE cycle right after DONE.
    for (int i = 0; i < tbl.size(); i++)
      run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].h, tbl[i].l,
             tbl[i].exp, tbl[i].lat, 1'b0);

    // Annul in CALC at cycle 5, then a fresh MULTU at cycle 7.
    begin
      bit early;
      early = 1'b0;
      bus.op = `MULT_CONTROL; bus.opdata1_i = 32'd5; bus.opdata2_i = 32'd5; bus.start_i = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        if (bus.ready_o || !bus.busy_o) early = 1'b1;
      end
      bus.annul_i = 1'b1;
      @(negedge clk);
      bus.annul_i = 1'b0;
      check("annul pre-state", 64'(early), 64'd0);
      check("annul idle at 6", {62'd0, bus.ready_o, bus.busy_o}, 64'd0);
      check("annul result held", bus.result_o, last_exp);
      @(negedge clk);
      run_op("post-annul multu", `MULTU_CONTROL, 32'd3, 32'd3, 32'd0, 32'd0, 64'h9, 18, 1'b0);
    end

    // start_i held high through DONE must not retrigger.
    run_op("held start", `MULTU_CONTROL, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0,
           64'h0000_0001_0000_0000, 18, 1'b1);

    ignored_start("unsupported op", 6'h20, 1'b0);
    ignored_start("start+annul", `MULT_CONTROL, 1'b1);
`ifndef MUL_MADD_EN
    ignored_start("maddu disabled", `MADDU_CONTROL, 1'b0);
    ignored_start("msub disabled", `MSUB_CONTROL, 1'b0);
`endif

    for (int i = 0; i < 30; i++) begin
      logic [5:0]  opc;
      logic [31:0] a, b, h, l;
`ifdef MUL_MADD_EN
      case ($urandom_range(0, 5))
        0: opc = `MULT_CONTROL;
        1: opc = `MULTU_CONTROL;
        2: opc = `MADD_CONTROL;
        3: opc = `MADDU_CONTROL;
        4: opc = `MSUB_CONTROL;
        default: opc = `MSUBU_CONTROL;
      endcase
`else
      opc = ($urandom_range(0, 1) == 0) ? `MULT_CONTROL : `MULTU_CONTROL;
`endif
      a = rnd_operand();
      b = rnd_operand();
      h = $urandom();
      l = $urandom();
      run_op($sformatf("rand%0d", i), opc, a, b, h, l, model(opc, a, b, h, l),
             (opc == `MULT_CONTROL || opc == `MULTU_CONTROL) ? 18 : 19, 1'b0);
    end

    // Asynchronous reset in the middle of CALC.
    check("pre-reset result", bus.result_o, last_exp);
    bus.op = `MULTU_CONTROL; bus.opdata1_i = 32'd11; bus.opdata2_i = 32'd13; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async reset result", bus.result_o, 64'h0);
    check("async reset ready/busy", {62'd0, bus.ready_o, bus.busy_o}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    last_exp = 64'h0;
    @(negedge clk);
    run_op("after reset", `MULT_CONTROL, 32'hffff_fffd, 32'd4, 32'd0, 32'd0,
           64'hffff_ffff_ffff_fff4, 18, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_vec);
    $fatal(1, "watchdog expired");
  end
endmodule
